// File: rtl/ccip_bk_pkg.sv
// Shared CCI-P c1 types and bookkeeping constants for the RX bookkeeper.
// Header layout follows the CCI-P c1 memory-request header.
package ccip_bk_pkg;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4,
        eREQ_INTR     = 4'h6
    } t_ccip_c1_req;

    typedef struct packed {
        logic [5:0]   rsvd2;
        t_ccip_vc     vc_sel;
        logic         sop;
        logic         rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    // Payload of one bookkeeping line; cons_cnt lands in data[31:0].
    typedef struct packed {
        logic [447:0] pad;
        logic [31:0]  seq;
        logic [31:0]  cons_cnt;
    } BkData;

    localparam t_ccip_c1_req BK_REQ_TYPE = eREQ_WRPUSH_I;
    localparam t_ccip_vc     BK_VC       = eVC_VH0;
    localparam t_ccip_clLen  BK_CL_LEN   = eCL_LEN_1;

endpackage

// File: rtl/ccip_bk_rr_picker.sv
// Combinational round-robin search: first set request bit at or after start_idx,
// wrapping at a runtime limit instead of at the array size.
module ccip_bk_rr_picker
    import ccip_bk_pkg::*;
#(
    parameter int LN = 1
) (
    input  logic [(1<<LN)-1:0] req,
    input  logic [LN-1:0]      limit,
    input  logic [LN-1:0]      start_idx,
    output logic               grant_valid,
    output logic [LN-1:0]      grant_idx
);

    localparam int N = 1 << LN;

    logic [LN:0] base;
    logic [LN:0] lim_ext;
    logic [LN:0] cand;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        lim_ext     = {1'b0, limit};
        base        = (start_idx > limit) ? '0 : {1'b0, start_idx};
        for (int off = 0; off < N; off++) begin
            cand = base + (LN+1)'(off);
            if (cand > lim_ext) begin
                cand = cand - (lim_ext + (LN+1)'(1));
            end
            if (!grant_valid && ((LN+1)'(off) <= lim_ext) && req[cand[LN-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[LN-1:0];
            end
        end
    end

endmodule

// File: rtl/ccip_rx_bookkeeper.sv
// Per-flow consumed-entry bookkeeping: counts poller events, coalesces them into
// batches or timeout flushes, and pushes one CCI-P c1 write per flow update.
module ccip_rx_bookkeeper
    import ccip_bk_pkg::*;
#(
    parameter int NIC_ID            = 0,
    parameter int LMAX_NUM_OF_FLOWS = 1,
    parameter int LBK_BATCH         = 2,
    parameter int LBK_TIMEOUT       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
    input  t_ccip_clAddr                 rx_bk_base_addr,
    input  logic [LBK_TIMEOUT-1:0]       bk_timeout,
    input  logic                         rpc_valid_in,
    input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
    input  logic                         sRx_c1TxAlmFull,
    output t_if_ccip_c1_Tx               sTx_c1,
    output logic [31:0]                  bk_writes_out,
    output logic                         error
);

    localparam int LN = LMAX_NUM_OF_FLOWS;
    localparam int NF = 1 << LN;
    localparam int PW = LBK_BATCH + 1;
    localparam logic [PW-1:0] PEND_FULL = PW'(1 << LBK_BATCH);

    if (NIC_ID < 0 || LN < 1 || LBK_BATCH < 0 || LBK_TIMEOUT < 1) begin : g_param_check
        $error("ccip_rx_bookkeeper[%0d]: illegal parameter set", NIC_ID);
    end

    logic                   s0_valid;
    logic [LN-1:0]          s0_flow;
    logic [31:0]            cons_cnt [NF];
    logic [PW-1:0]          pending  [NF];
    logic [NF-1:0]          flush;
    logic [NF-1:0]          eligible;
    logic                   any_pending;
    logic [LBK_TIMEOUT-1:0] timer;
    logic                   timer_fire;
    logic [LN-1:0]          rr_ptr;
    logic [31:0]            seq_num;
    logic                   grant_valid;
    logic [LN-1:0]          grant_idx;
    logic                   fire;
    t_ccip_c1_ReqMemHdr     hdr_next;
    BkData                  data_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_flow  <= '0;
            error    <= 1'b0;
        end else begin
            s0_valid <= rpc_valid_in && (rpc_flow_id_in <= number_of_flows);
            s0_flow  <= rpc_flow_id_in;
            if (rpc_valid_in && (rpc_flow_id_in > number_of_flows)) begin
                error <= 1'b1;
            end
        end
    end

    always_comb begin
        eligible    = '0;
        any_pending = 1'b0;
        for (int f = 0; f < NF; f++) begin
            eligible[f] = (pending[f] == PEND_FULL) || (flush[f] && (pending[f] != '0));
            if (pending[f] != '0) begin
                any_pending = 1'b1;
            end
        end
    end

    ccip_bk_rr_picker #(
        .LN (LN)
    ) u_picker (
        .req         (eligible),
        .limit       (number_of_flows),
        .start_idx   (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign fire       = grant_valid && start && !sRx_c1TxAlmFull;
    assign timer_fire = (bk_timeout != '0) && any_pending && (timer == bk_timeout);

    // NOTE: the per-flow arrays are reset explicitly; an async reset must leave
    // no stale count behind, so they are flops, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < NF; f++) begin
                cons_cnt[f] <= '0;
                pending[f]  <= '0;
            end
            flush <= '0;
        end else begin
            for (int f = 0; f < NF; f++) begin
                if (s0_valid && (s0_flow == LN'(f))) begin
                    cons_cnt[f] <= cons_cnt[f] + 32'd1;
                end
                // An increment landing in the grant cycle seeds the next batch.
                if (fire && (grant_idx == LN'(f))) begin
                    pending[f] <= (s0_valid && (s0_flow == LN'(f))) ? PW'(1) : '0;
                    flush[f]   <= 1'b0;
                end else begin
                    if (s0_valid && (s0_flow == LN'(f)) && (pending[f] != PEND_FULL)) begin
                        pending[f] <= pending[f] + PW'(1);
                    end
                    if (timer_fire && (pending[f] != '0)) begin
                        flush[f] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if ((bk_timeout != '0) && any_pending) begin
            timer <= timer_fire ? '0 : timer + LBK_TIMEOUT'(1);
        end else begin
            timer <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (grant_idx == number_of_flows) ? '0 : grant_idx + LN'(1);
        end
    end

    always_comb begin
        hdr_next          = '0;
        hdr_next.vc_sel   = BK_VC;
        hdr_next.sop      = 1'b1;
        hdr_next.cl_len   = BK_CL_LEN;
        hdr_next.req_type = BK_REQ_TYPE;
        hdr_next.address  = rx_bk_base_addr + t_ccip_clAddr'(grant_idx);
        hdr_next.mdata    = t_ccip_mdata'(grant_idx);
        data_next          = '0;
        data_next.cons_cnt = cons_cnt[grant_idx];
        data_next.seq      = seq_num;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sTx_c1        <= '0;
            seq_num       <= '0;
            bk_writes_out <= '0;
        end else begin
            sTx_c1.valid <= fire;
            if (fire) begin
                sTx_c1.hdr    <= hdr_next;
                sTx_c1.data   <= t_ccip_clData'(data_next);
                seq_num       <= seq_num + 32'd1;
                bk_writes_out <= bk_writes_out + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_rx_bookkeeper.sv
// Scoreboard bench for ccip_rx_bookkeeper: stimulus pushes expected writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_ccip_rx_bookkeeper;
    import ccip_bk_pkg::*;

    localparam int LN = 2;
    localparam int NF = 1 << LN;

    logic           clk;
    logic           reset;
    logic           start;
    logic [LN-1:0]  number_of_flows;
    t_ccip_clAddr   rx_bk_base_addr;
    logic [7:0]     bk_timeout;
    logic           rpc_valid_in;
    logic [LN-1:0]  rpc_flow_id_in;
    logic           sRx_c1TxAlmFull;
    t_if_ccip_c1_Tx sTx_c1;
    logic [31:0]    bk_writes_out;
    logic           error;

    ccip_rx_bookkeeper #(
        .NIC_ID            (0),
        .LMAX_NUM_OF_FLOWS (LN),
        .LBK_BATCH         (2),
        .LBK_TIMEOUT       (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .number_of_flows (number_of_flows),
        .rx_bk_base_addr (rx_bk_base_addr),
        .bk_timeout      (bk_timeout),
        .rpc_valid_in    (rpc_valid_in),
        .rpc_flow_id_in  (rpc_flow_id_in),
        .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
        .sTx_c1          (sTx_c1),
        .bk_writes_out   (bk_writes_out),
        .error           (error)
    );

    typedef struct {
        int          flow;
        logic [31:0] cons;
        logic [31:0] seq;
        int          lo;
        int          hi;
    } exp_t;

    exp_t        exp_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          writes_seen = 0;
    logic [31:0] m_cnt  [NF];
    int          m_pend [NF];
    logic [31:0] m_seq;
    logic        m_err;
    bit          m_auto;
    int          last_ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input int v, input int lo, input int hi);
        total_cnt++;
        if (v >= lo && v <= hi) pass_cnt++;
        else $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, v, lo, hi);
    endtask

    always @(negedge clk) begin
        if (!reset && sTx_c1.valid) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr=0x%0h cons=%0d, expected no write",
                         sTx_c1.hdr.address, sTx_c1.data[31:0]);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 64'(sTx_c1.hdr.address), 64'(rx_bk_base_addr + t_ccip_clAddr'(e.flow)));
                check("wr_cons_cnt", 64'(sTx_c1.data[31:0]), 64'(e.cons));
                check("wr_seq", 64'(sTx_c1.data[63:32]), 64'(e.seq));
                check("wr_pad_zero", 64'(sTx_c1.data[511:64] == '0), 64'(1));
                check("wr_mdata", 64'(sTx_c1.hdr.mdata[LN-1:0]), 64'(e.flow));
                check("wr_req_type", 64'(sTx_c1.hdr.req_type), 64'(eREQ_WRPUSH_I));
                check("wr_vc_cl_sop", 64'({sTx_c1.hdr.vc_sel, sTx_c1.hdr.cl_len, sTx_c1.hdr.sop}),
                      64'({eVC_VH0, eCL_LEN_1, 1'b1}));
                check("wr_bk_writes_out", 64'(bk_writes_out), 64'(e.seq + 32'd1));
                check_range("wr_cycle", cyc, e.lo, e.hi);
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        for (int f = 0; f < NF; f++) begin
            m_cnt[f]  = '0;
            m_pend[f] = 0;
        end
        m_seq = '0;
        m_err = 1'b0;
    endtask

    task automatic push_exp(input int f, input int lo, input int hi);
        exp_t e;
        e.flow = f; e.cons = m_cnt[f]; e.seq = m_seq; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
        m_seq = m_seq + 32'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // One consumed entry; every 2^LBK_BATCH-th legal entry of a flow completes a batch.
    task automatic ev(input int f);
        rpc_valid_in   = 1'b1;
        rpc_flow_id_in = LN'(f);
        last_ev        = cyc + 1;
        if (f > int'(number_of_flows)) begin
            m_err = 1'b1;
        end else begin
            m_cnt[f] = m_cnt[f] + 32'd1;
            m_pend[f]++;
            if (m_auto && m_pend[f] == 4) begin
                push_exp(f, last_ev + 2, last_ev + 2);
                m_pend[f] = 0;
            end
        end
        @(posedge clk); #1;
        rpc_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rpc_valid_in = 1'b0;
        reset = 1'b1;
        model_clear();
        idle(2);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        logic [63:0] r64;
        int          w0;
        bit          seen;
        int          k;

        reset = 1'b1;
        start = 1'b0;
        number_of_flows = LN'(1);
        r64 = {$urandom(), $urandom()};
        rx_bk_base_addr = r64[41:0];
        bk_timeout = '0;
        rpc_valid_in = 1'b0;
        rpc_flow_id_in = '0;
        sRx_c1TxAlmFull = 1'b0;
        m_auto = 1'b1;
        model_clear();

        idle(3);
        check("rst_valid", 64'(sTx_c1.valid), 64'(0));
        check("rst_hdr_zero", 64'(sTx_c1.hdr == '0), 64'(1));
        check("rst_bk_writes", 64'(bk_writes_out), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        reset = 1'b0;
        start = 1'b1;

        // Basic batch on flow 1
        for (int i = 0; i < 4; i++) ev(1);
        drain("basic");
        check("basic_bk_writes", 64'(bk_writes_out), 64'(1));

        // Back-to-back events on flow 0: the fifth lands in the grant cycle
        for (int i = 0; i < 8; i++) ev(0);
        drain("collision");
        ev(3);
        idle(3);
        check("illegal_error", 64'(error), 64'(m_err));
        for (int i = 0; i < 4; i++) ev(1);
        drain("after_illegal");

        // Randomised traffic under different flow limits
        for (int rep = 0; rep < 3; rep++) begin
            do_reset();
            number_of_flows = LN'(rep + 1);
            for (int i = 0; i < 120; i++) begin
                idle($urandom_range(0, 2));
                ev($urandom_range(0, NF - 1));
            end
            drain("random");
            check("random_error", 64'(error), 64'(m_err));
        end

        // Fairness: flows 0 and 1 both full when backpressure lifts
        do_reset();
        number_of_flows = LN'(1);
        m_auto = 1'b0;
        sRx_c1TxAlmFull = 1'b1;
        for (int i = 0; i < 4; i++) ev(0);
        for (int i = 0; i < 4; i++) ev(1);
        idle(3);
        sRx_c1TxAlmFull = 1'b0;
        k = cyc;
        push_exp(0, k + 1, k + 1);
        push_exp(1, k + 2, k + 2);
        drain("fairness");

        // Long stall: pending saturates, cons_cnt stays exact
        do_reset();
        sRx_c1TxAlmFull = 1'b1;
        w0 = writes_seen;
        for (int i = 0; i < 12; i++) begin
            ev(0);
            idle($urandom_range(0, 2));
        end
        idle(50 - 12);
        check("stall_no_write", 64'(writes_seen - w0), 64'(0));
        sRx_c1TxAlmFull = 1'b0;
        k = cyc;
        push_exp(0, k + 1, k + 1);
        drain("stall");
        idle(20);
        check("stall_single_write", 64'(writes_seen - w0), 64'(1));

        // Timeout flush of a partial batch
        do_reset();
        m_auto = 1'b1;
        bk_timeout = 8'd10;
        w0 = writes_seen;
        ev(0);
        push_exp(0, last_ev + 2, last_ev + 13);
        drain("timeout");
        idle(40);
        check("timeout_single_write", 64'(writes_seen - w0), 64'(1));
        bk_timeout = '0;

        // Async reset while a write is on the bus
        do_reset();
        m_auto = 1'b0;
        for (int i = 0; i < 4; i++) ev(1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (sTx_c1.valid) seen = 1'b1;
        end
        check("areset_valid_seen", 64'(seen), 64'(1));
        reset = 1'b1;
        #1;
        check("areset_valid_drop", 64'(sTx_c1.valid), 64'(0));
        check("areset_bk_writes", 64'(bk_writes_out), 64'(0));
        model_clear();
        idle(2);
        reset = 1'b0;
        m_auto = 1'b1;
        for (int i = 0; i < 4; i++) ev(1);
        drain("after_areset");
        check("final_error", 64'(error), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
